pokey_bus_arbiter: RTL and testbench

POKEY_BUS_ARBITER -- requirements
Module: pokey_bus_arbiter

---
 rtl/pokey_bus_arbiter_if.sv | 37 +++
 rtl/pokey_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_pokey_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pokey_bus_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : pokey_bus_arbiter_if
// Brief   : Requester handshakes plus POKEY bus signals for the two-port
//           POKEY arbiter. "master" is the system side (requesters and the
//           POKEY data return); "slave" is the arbiter itself.
// Revision: 1.0 - initial release
// ============================================================================
interface pokey_bus_arbiter_if;
  logic       req0, req1;
  logic       we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       done0, done1;
  logic [7:0] rdata0, rdata1;
  logic       ready;
  logic       phi2;
  logic       cs0Bar;
  logic       readHighWriteLow;
  logic [3:0] pokeyA;
  logic [7:0] pokeyDin;
  logic [7:0] pokeyDout;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, pokeyDout,
    input  done0, done1, rdata0, rdata1, ready, phi2, cs0Bar,
           readHighWriteLow, pokeyA, pokeyDin
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, pokeyDout,
    output done0, done1, rdata0, rdata1, ready, phi2, cs0Bar,
           readHighWriteLow, pokeyA, pokeyDin
  );
endinterface
`default_nettype wire

// File: rtl/pokey_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : pokey_bus_arbiter
// Brief   : Generates phi2 for a POKEY and shares its bus between two
//           requesters, one access per phi2 slot (low phase + high phase).
//           Issues an SKCTL init write after reset before serving requests.
// Revision: 1.0 - initial release
// ============================================================================
module pokey_bus_arbiter #(
  parameter int         HALF_LEN   = 29,
  parameter int         RR_MODE    = 1,
  parameter logic [7:0] SKCTL_INIT = 8'h03
) (
  input  logic                       clk,
  input  logic                       clrBar,
  pokey_bus_arbiter_if.slave         bus
);

  localparam int            CW   = $clog2(HALF_LEN);
  localparam logic [CW-1:0] LAST = CW'(HALF_LEN - 1);

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    INIT       = 2'd1,
    RUN        = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          phi2_q;
  logic          boundary;

  // Slot registers: what the POKEY sees for the whole current slot
  logic       cs_n_q, cs_n_nxt;
  logic       rw_q, rw_nxt;
  logic [3:0] a_q, a_nxt;
  logic [7:0] din_q, din_nxt;
  logic       gnt_v_q, gnt_v_nxt;    // current slot carries a requester access
  logic       gnt_p_q, gnt_p_nxt;    // which port owns it
  logic       gnt_we_q, gnt_we_nxt;  // and whether it is a write
  logic       ptr_q, ptr_nxt;        // last port granted
  logic       ready_q, ready_nxt;

  logic [1:0] done_q;
  logic [7:0] rdata0_q, rdata1_q;

  logic elig0, elig1, pick;

  // A port that is completing in the slot now ending sits out one slot
  assign elig0 = bus.req0 && !(gnt_v_q && !gnt_p_q);
  assign elig1 = bus.req1 && !(gnt_v_q && gnt_p_q);
  assign pick  = (elig0 && elig1) ? ((RR_MODE != 0) ? ~ptr_q : 1'b0) : elig1;

  assign boundary = phi2_q && (cnt == LAST);

  // Free-running phase counter and phi2 generator
  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      cnt    <= '0;
      phi2_q <= 1'b0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      phi2_q <= ~phi2_q;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) state <= RESET_WAIT;
    else         state <= state_nxt;
  end

  // Next state and next-slot bus contents, decided only at slot boundaries
  always_comb begin
    state_nxt  = state;
    cs_n_nxt   = cs_n_q;
    rw_nxt     = rw_q;
    a_nxt      = a_q;
    din_nxt    = din_q;
    gnt_v_nxt  = gnt_v_q;
    gnt_p_nxt  = gnt_p_q;
    gnt_we_nxt = gnt_we_q;
    ptr_nxt    = ptr_q;
    ready_nxt  = ready_q;
    if (boundary) begin
      case (state)
        RESET_WAIT: begin
          state_nxt = INIT;
          gnt_v_nxt = 1'b0;
          cs_n_nxt  = 1'b0;
          rw_nxt    = 1'b0;
          a_nxt     = 4'hF;
          din_nxt   = SKCTL_INIT;
        end
        INIT, RUN: begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
          if (elig0 || elig1) begin
            gnt_v_nxt  = 1'b1;
            gnt_p_nxt  = pick;
            gnt_we_nxt = pick ? bus.we1 : bus.we0;
            ptr_nxt    = pick;
            cs_n_nxt   = 1'b0;
            rw_nxt     = ~gnt_we_nxt;
            a_nxt      = pick ? bus.addr1 : bus.addr0;
            din_nxt    = gnt_we_nxt ? (pick ? bus.wdata1 : bus.wdata0) : 8'h00;
          end else begin
            gnt_v_nxt  = 1'b0;
            cs_n_nxt   = 1'b1;
            rw_nxt     = 1'b1;
          end
        end
        default: state_nxt = RESET_WAIT;
      endcase
    end
  end

  // Slot registers load the decisions made above
  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      cs_n_q   <= 1'b1;
      rw_q     <= 1'b1;
      a_q      <= 4'h0;
      din_q    <= 8'h00;
      gnt_v_q  <= 1'b0;
      gnt_p_q  <= 1'b0;
      gnt_we_q <= 1'b0;
      ptr_q    <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      cs_n_q   <= cs_n_nxt;
      rw_q     <= rw_nxt;
      a_q      <= a_nxt;
      din_q    <= din_nxt;
      gnt_v_q  <= gnt_v_nxt;
      gnt_p_q  <= gnt_p_nxt;
      gnt_we_q <= gnt_we_nxt;
      ptr_q    <= ptr_nxt;
      ready_q  <= ready_nxt;
    end
  end

  // Completion pulse and read capture at the boundary ending a granted slot
  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      done_q   <= 2'b00;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
    end else begin
      done_q[0] <= boundary && gnt_v_q && !gnt_p_q;
      done_q[1] <= boundary && gnt_v_q && gnt_p_q;
      if (boundary && gnt_v_q && !gnt_we_q) begin
        if (gnt_p_q) rdata1_q <= bus.pokeyDout;
        else         rdata0_q <= bus.pokeyDout;
      end
    end
  end

  assign bus.phi2             = phi2_q;
  assign bus.cs0Bar           = cs_n_q;
  assign bus.readHighWriteLow = rw_q;
  assign bus.pokeyA           = a_q;
  assign bus.pokeyDin         = din_q;
  assign bus.ready            = ready_q;
  assign bus.done0            = done_q[0];
  assign bus.done1            = done_q[1];
  assign bus.rdata0           = rdata0_q;
  assign bus.rdata1           = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_pokey_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_pokey_bus_arbiter
// Brief   : Self-checking bench for pokey_bus_arbiter with a slot-level
//           reference model of the arbitration rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pokey_bus_arbiter;

  localparam int         HL = 4;
  localparam int         RR = 1;
  localparam logic [7:0] SK = 8'h03;

  logic clk = 1'b0;
  logic clrBar = 1'b0;
  always #5 clk = ~clk;

  pokey_bus_arbiter_if bus ();

  pokey_bus_arbiter #(.HALF_LEN(HL), .RR_MODE(RR), .SKCTL_INIT(SK)) dut (
    .clk    (clk),
    .clrBar (clrBar),
    .bus    (bus)
  );

  // Requester / POKEY stimulus
  logic [1:0] t_req = 2'b00;
  logic [1:0] t_we  = 2'b00;
  logic [3:0] t_addr [2] = '{4'h0, 4'h0};
  logic [7:0] t_wdata[2] = '{8'h00, 8'h00};
  logic [7:0] t_dout = 8'h00;
  logic [7:0] dout_val = 8'h00;
  bit         rand_dout = 1'b0;

  assign bus.req0 = t_req[0];
  assign bus.req1 = t_req[1];
  assign bus.we0 = t_we[0];
  assign bus.we1 = t_we[1];
  assign bus.addr0 = t_addr[0];
  assign bus.addr1 = t_addr[1];
  assign bus.wdata0 = t_wdata[0];
  assign bus.wdata1 = t_wdata[1];
  assign bus.pokeyDout = t_dout;

  int errors = 0;
  int checks = 0;
  int obs_done[2] = '{0, 0};

  // Reference model: one update per slot
  int         m_slot;
  logic       m_gv, m_gp, m_gwe, m_last, m_ready;
  logic       m_cs, m_rw;
  logic [3:0] m_a;
  logic [7:0] m_din;
  logic [7:0] m_rd[2];
  logic [1:0] m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_slot = 0; m_gv = 1'b0; m_gp = 1'b0; m_gwe = 1'b0; m_last = 1'b1;
    m_ready = 1'b0; m_cs = 1'b1; m_rw = 1'b1; m_a = 4'h0; m_din = 8'h00;
    m_rd[0] = 8'h00; m_rd[1] = 8'h00; m_done = 2'b00;
  endtask

  task automatic model_boundary();
    logic e0, e1, g;
    m_done = 2'b00;
    if (m_gv) begin
      m_done[m_gp] = 1'b1;
      if (!m_gwe) m_rd[m_gp] = t_dout;
    end
    m_slot++;
    if (m_slot == 1) begin
      m_gv = 1'b0; m_cs = 1'b0; m_rw = 1'b0; m_a = 4'hF; m_din = SK;
    end else begin
      m_ready = 1'b1;
      e0 = t_req[0] && !(m_gv && (m_gp == 1'b0));
      e1 = t_req[1] && !(m_gv && (m_gp == 1'b1));
      if (e0 && e1) g = (RR != 0) ? ~m_last : 1'b0;
      else          g = e1;
      if (e0 || e1) begin
        m_last = g; m_gv = 1'b1; m_gp = g; m_gwe = t_we[g];
        m_cs = 1'b0; m_rw = ~t_we[g]; m_a = t_addr[g];
        m_din = t_we[g] ? t_wdata[g] : 8'h00;
      end else begin
        m_gv = 1'b0; m_cs = 1'b1; m_rw = 1'b1;
      end
    end
  endtask

  task automatic check_slot(input string ph);
    chk({ph, "_cs0Bar"}, 32'(bus.cs0Bar), 32'(m_cs));
    chk({ph, "_rw"}, 32'(bus.readHighWriteLow), 32'(m_rw));
    chk({ph, "_pokeyA"}, 32'(bus.pokeyA), 32'(m_a));
    chk({ph, "_pokeyDin"}, 32'(bus.pokeyDin), 32'(m_din));
  endtask

  task automatic check_reset_state();
    chk("rst_phi2", 32'(bus.phi2), 32'(0));
    chk("rst_cs0Bar", 32'(bus.cs0Bar), 32'(1));
    chk("rst_rw", 32'(bus.readHighWriteLow), 32'(1));
    chk("rst_pokeyA", 32'(bus.pokeyA), 32'(0));
    chk("rst_pokeyDin", 32'(bus.pokeyDin), 32'(0));
    chk("rst_done", 32'({bus.done1, bus.done0}), 32'(0));
    chk("rst_rdata0", 32'(bus.rdata0), 32'(0));
    chk("rst_rdata1", 32'(bus.rdata1), 32'(0));
    chk("rst_ready", 32'(bus.ready), 32'(0));
  endtask

  // Runs one slot starting just after a boundary (or reset release);
  // abort_at != 0 pulls clrBar low at that cycle of the slot instead.
  task automatic run_slot(input int abort_at);
    for (int p = 1; p <= 2 * HL; p++) begin
      @(negedge clk);
      if (abort_at != 0 && p == abort_at) begin
        clrBar = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state();
        clrBar = 1'b1;
        return;
      end
      chk("phi2", 32'(bus.phi2), 32'(p >= HL && p < 2 * HL));
      if (p == 1) chk("done_width", 32'({bus.done1, bus.done0}), 32'(0));
      if (p == HL) begin
        t_dout = rand_dout ? 8'($urandom) : dout_val;
        check_slot("mid");
      end
      if (p == 2 * HL) begin
        model_boundary();
        check_slot("new");
        chk("done0", 32'(bus.done0), 32'(m_done[0]));
        chk("done1", 32'(bus.done1), 32'(m_done[1]));
        chk("rdata0", 32'(bus.rdata0), 32'(m_rd[0]));
        chk("rdata1", 32'(bus.rdata1), 32'(m_rd[1]));
        chk("ready", 32'(bus.ready), 32'(m_ready));
        obs_done[0] += int'(bus.done0);
        obs_done[1] += int'(bus.done1);
      end
    end
  endtask

  // Legal random requester behaviour for the slot just starting
  task automatic randomize_inputs();
    for (int k = 0; k < 2; k++) begin
      if (m_gv && (int'(m_gp) == k)) continue;
      if (t_req[k] && !m_done[k]) begin
        if ($urandom_range(2) == 0) t_req[k] = 1'b0;
      end else begin
        t_req[k]   = ($urandom_range(3) != 0);
        t_we[k]    = 1'($urandom_range(1));
        t_addr[k]  = 4'($urandom);
        t_wdata[k] = 8'($urandom);
      end
    end
  endtask

  task automatic set_port(input int k, input logic r, input logic w,
                          input logic [3:0] a, input logic [7:0] d);
    t_req[k] = r; t_we[k] = w; t_addr[k] = a; t_wdata[k] = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state();
    clrBar = 1'b1;

    // Partial slot, then INIT with a write request already pending
    run_slot(0);
    chk("init_A", 32'(bus.pokeyA), 32'(4'hF));
    chk("init_Din", 32'(bus.pokeyDin), 32'(SK));
    set_port(0, 1'b1, 1'b1, 4'h1, 8'hA5);
    run_slot(0);
    chk("wr_A", 32'(bus.pokeyA), 32'(4'h1));
    chk("wr_Din", 32'(bus.pokeyDin), 32'(8'hA5));
    obs_done = '{0, 0};
    run_slot(0);
    t_req[0] = 1'b0;
    run_slot(0);
    chk("wr_done0_count", 32'(obs_done[0]), 32'(1));
    chk("wr_done1_count", 32'(obs_done[1]), 32'(0));

    // Read by port 1
    dout_val = 8'h5C;
    set_port(1, 1'b1, 1'b0, 4'hA, 8'h77);
    run_slot(0);
    chk("rd_Din", 32'(bus.pokeyDin), 32'(0));
    run_slot(0);
    chk("rd_rdata1", 32'(bus.rdata1), 32'(8'h5C));
    t_req[1] = 1'b0;
    run_slot(0);

    // Contention: both ports hold req
    set_port(0, 1'b1, 1'b1, 4'h2, 8'h11);
    set_port(1, 1'b1, 1'b1, 4'h3, 8'h22);
    run_slot(0);
    chk("cont_first_A", 32'(bus.pokeyA), 32'(4'h2));
    obs_done = '{0, 0};
    run_slot(0);
    run_slot(0);
    run_slot(0);
    t_req[0] = 1'b0;
    run_slot(0);
    t_req[1] = 1'b0;
    chk("cont_done0_count", 32'(obs_done[0]), 32'(2));
    chk("cont_done1_count", 32'(obs_done[1]), 32'(2));
    run_slot(0);

    // Single streamer on port 0
    set_port(0, 1'b1, 1'b1, 4'h5, 8'h5A);
    run_slot(0);
    obs_done = '{0, 0};
    repeat (5) run_slot(0);
    t_req[0] = 1'b0;
    run_slot(0);
    chk("stream_done0_count", 32'(obs_done[0]), 32'(3));
    chk("stream_idle_cs", 32'(bus.cs0Bar), 32'(1));

    // Randomized traffic
    rand_dout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      randomize_inputs();
      run_slot(0);
    end
    t_req = 2'b00;
    run_slot(0);
    run_slot(0);

    // Reset during the high phase of a granted write
    set_port(0, 1'b1, 1'b1, 4'h7, 8'h3C);
    run_slot(0);
    chk("abort_pre_cs", 32'(bus.cs0Bar), 32'(0));
    run_slot(HL + 1);
    obs_done = '{0, 0};
    run_slot(0);
    chk("reinit_A", 32'(bus.pokeyA), 32'(4'hF));
    chk("reinit_Din", 32'(bus.pokeyDin), 32'(SK));
    run_slot(0);
    chk("reissue_A", 32'(bus.pokeyA), 32'(4'h7));
    run_slot(0);
    t_req[0] = 1'b0;
    run_slot(0);
    chk("abort_done0_count", 32'(obs_done[0]), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
